popcount32_arbiter: RTL and testbench

- Round-robin scheduler that shares one fixed-latency, path-balanced 32-input population-count datapath among NREQ requesters.
- Accepts 32-bit words from the requesters over valid/ready and issues at most one word per cycle to the counter.
- Tracks the owner of each word through a tag pipeline matched to the counter depth, then returns the 6-bit count to the owner through a one-entry result slot with valid/ready.
- Sits between the request sources and the external counter instance; does not instantiate the counter.

---
 rtl/popcount32_arbiter.sv | 162 ++++++++++++++++
 tb/tb_popcount32_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount32_arbiter.sv
// popcount32_arbiter
//
// Round-robin front end for a shared, fixed-latency 32-bit population counter.
// Requesters offer words over valid/ready. At most one word per cycle is issued
// to the external counter, which is not instantiated here. A {valid, tag}
// pipeline follows each word through the counter, and the 6-bit count is
// returned to its owner through a one-entry result slot with valid/ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid[NREQ]     requester i offers a word
//   req_data[NREQ*32]   word of requester i in bits [32i+31:32i]
//   req_ready[NREQ]     one-hot grant (all zeros when nothing is eligible)
//   pc_valid, pc_in     word presented to the counter this cycle (0 when idle)
//   pc_out[6]           counter result for the pc_in of LATENCY cycles ago
//   rsp_valid[NREQ]     result slot i holds a count
//   rsp_count[NREQ*6]   count for requester i in bits [6i+5:6i]
//   rsp_ready[NREQ]     requester i accepts its result
//   busy                at least one requester has a word in flight or unread
module popcount32_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              pc_valid,
    output logic [31:0]       pc_in,
    input  logic [5:0]        pc_out,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*6-1:0] rsp_count,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic              busy
);
    localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] pending_q, pending_d;
    logic [TAGW-1:0] ptr_q, ptr_d;
    logic [31:0]     pc_in_q, pc_in_d;

    // Stage 0 is the issue register; stage LATENCY lines up with pc_out.
    logic            stage_valid_q [0:LATENCY];
    logic            stage_valid_d [0:LATENCY];
    logic [TAGW-1:0] stage_tag_q   [0:LATENCY];
    logic [TAGW-1:0] stage_tag_d   [0:LATENCY];

    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [5:0]      rsp_count_q [NREQ];
    logic [5:0]      rsp_count_d [NREQ];

    logic [31:0]     req_word [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] rsp_hs;
    logic [NREQ-1:0] res_mask;
    logic [NREQ-1:0] grant_onehot;
    logic            grant_any;
    logic [TAGW-1:0] grant_idx;
    logic [TAGW-1:0] scan_tag;
    int              scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign req_word[gi]            = req_data[32*gi +: 32];
            assign res_mask[gi]            = stage_valid_q[LATENCY] &&
                                             (stage_tag_q[LATENCY] == TAGW'(gi));
            assign rsp_count[6*gi +: 6]    = rsp_count_q[gi];
        end
    endgenerate

    // One credit per requester: a requester with a word in flight or an
    // unread result is not eligible.
    assign eligible = req_valid & ~pending_q;
    assign rsp_hs   = rsp_valid_q & rsp_ready;

    // Rotating priority scan starting at ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        scan_tag  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_tag = TAGW'(scan_idx);
            if (!grant_any && eligible[scan_tag]) begin
                grant_any = 1'b1;
                grant_idx = scan_tag;
            end
        end
    end

    assign grant_onehot = grant_any ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        pending_d = (pending_q | grant_onehot) & ~rsp_hs;
        ptr_d     = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == TAGW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        pc_in_d          = grant_any ? req_word[grant_idx] : 32'd0;
        stage_valid_d[0] = grant_any;
        stage_tag_d[0]   = grant_idx;
        for (int k = 1; k <= LATENCY; k++) begin
            stage_valid_d[k] = stage_valid_q[k-1];
            stage_tag_d[k]   = stage_tag_q[k-1];
        end
    end

    // Result capture and response handshake never target the same slot
    // in one cycle, so the two updates below are independent.
    always_comb begin
        rsp_valid_d = (rsp_valid_q & ~rsp_hs) | res_mask;
        for (int k = 0; k < NREQ; k++) begin
            rsp_count_d[k] = res_mask[k] ? pc_out : rsp_count_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            ptr_q       <= '0;
            pc_in_q     <= '0;
            rsp_valid_q <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                stage_valid_q[k] <= 1'b0;
                stage_tag_q[k]   <= '0;
            end
            for (int k = 0; k < NREQ; k++) begin
                rsp_count_q[k] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            pc_in_q     <= pc_in_d;
            rsp_valid_q <= rsp_valid_d;
            for (int k = 0; k <= LATENCY; k++) begin
                stage_valid_q[k] <= stage_valid_d[k];
                stage_tag_q[k]   <= stage_tag_d[k];
            end
            for (int k = 0; k < NREQ; k++) begin
                rsp_count_q[k] <= rsp_count_d[k];
            end
        end
    end

    // Grant is masked during reset so every output reads 0 immediately.
    assign req_ready = rst ? '0 : grant_onehot;
    assign pc_valid  = stage_valid_q[0];
    assign pc_in     = pc_in_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = |pending_q;

    a_no_result_on_handshake : assert property (
        @(posedge clk) disable iff (rst) ((res_mask & rsp_hs) == '0)
    );

endmodule

// File: tb/tb_popcount32_arbiter.sv
module tb_popcount32_arbiter;
    localparam int N = 4;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default build (LATENCY = 4)
    logic [N-1:0]    req_valid = '0, rsp_ready = '0;
    logic [N*32-1:0] req_data  = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic            pc_valid, busy;
    logic [31:0]     pc_in;
    logic [5:0]      pc_out;
    logic [N*6-1:0]  rsp_count;

    // Combinational-counter build (LATENCY = 0)
    logic [N-1:0]    req_valid0 = '0, rsp_ready0 = '0;
    logic [N*32-1:0] req_data0  = '0;
    logic [N-1:0]    req_ready0, rsp_valid0;
    logic            pc_valid0, busy0;
    logic [31:0]     pc_in0;
    logic [5:0]      pc_out0;
    logic [N*6-1:0]  rsp_count0;

    int total = 0;
    int bad   = 0;

    popcount32_arbiter #(.NREQ(N), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pc_valid(pc_valid), .pc_in(pc_in),
        .pc_out(pc_out), .rsp_valid(rsp_valid), .rsp_count(rsp_count),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    popcount32_arbiter #(.NREQ(N), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .pc_valid(pc_valid0), .pc_in(pc_in0),
        .pc_out(pc_out0), .rsp_valid(rsp_valid0), .rsp_count(rsp_count0),
        .rsp_ready(rsp_ready0), .busy(busy0)
    );

    // External counters: a pipelined one of depth L and a combinational one.
    logic [5:0] cnt_pipe [L] = '{default: 6'd0};
    always @(posedge clk) begin
        cnt_pipe[0] <= 6'($countones(pc_in));
        for (int k = 1; k < L; k++) cnt_pipe[k] <= cnt_pipe[k-1];
    end
    assign pc_out  = cnt_pipe[L-1];
    assign pc_out0 = 6'($countones(pc_in0));

    // Reference model: per-requester credit, grant cycle and captured word.
    // A result is expected from grant cycle + 2 + L until it is accepted.
    logic [N-1:0] m_pend = '0;
    int           m_gcyc [N];
    logic [31:0]  m_word [N];
    int           m_ptr = 0;
    int           m_cyc = 0;
    logic         m_iss_v = 1'b0;
    logic [31:0]  m_iss_w = '0;
    int           e_grant;
    logic [N-1:0] e_ready, e_rsp_valid;

    always_comb begin
        e_grant = -1;
        for (int k = 0; k < N; k++) begin
            if (e_grant < 0 && req_valid[(m_ptr + k) % N] && !m_pend[(m_ptr + k) % N])
                e_grant = (m_ptr + k) % N;
        end
        e_ready = '0;
        if (!rst && e_grant >= 0) e_ready[e_grant] = 1'b1;
        e_rsp_valid = '0;
        for (int i = 0; i < N; i++)
            e_rsp_valid[i] = m_pend[i] && (m_cyc >= m_gcyc[i] + 2 + L);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= '0;
            m_ptr   <= 0;
            m_cyc   <= 0;
            m_iss_v <= 1'b0;
            m_iss_w <= '0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_pend <= (m_pend | e_ready) & ~(e_rsp_valid & rsp_ready);
            if (e_grant >= 0) begin
                m_gcyc[e_grant] <= m_cyc;
                m_word[e_grant] <= req_data[32*e_grant +: 32];
                m_ptr           <= (e_grant + 1) % N;
                m_iss_v         <= 1'b1;
                m_iss_w         <= req_data[32*e_grant +: 32];
            end else begin
                m_iss_v <= 1'b0;
                m_iss_w <= '0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; req_valid0 = '0; rsp_ready0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1; rsp_ready = '1; req_data = {4{32'hDEADBEEF}};
        req_valid0 = '1; rsp_ready0 = '1;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, pc_valid, pc_in, rsp_valid, rsp_count, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b pcv=%b pc_in=%h rspv=%b cnt=%h busy=%b want all 0",
                     req_ready, pc_valid, pc_in, rsp_valid, rsp_count, busy);
        end
        total++;
        if ({req_ready0, pc_valid0, pc_in0, rsp_valid0, rsp_count0, busy0} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_lat0 got ready=%b rspv=%b busy=%b want all 0",
                     req_ready0, rsp_valid0, busy0);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        rsp_ready = '1;
        for (int c = 0; c < 9; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            req_data[31:0] = 32'hFFFF_FFFF;
            #1;
            if (c == 0) begin
                total++;
                if (req_ready !== 4'b0001) begin
                    bad++; $display("FAIL single_grant got=%b want=0001", req_ready);
                end
            end
            if (c == 1) begin
                total++;
                if (pc_valid !== 1'b1 || pc_in !== 32'hFFFF_FFFF) begin
                    bad++; $display("FAIL single_issue got v=%b d=%h want v=1 d=ffffffff", pc_valid, pc_in);
                end
            end
            if (c >= 2 && c <= 5) begin
                total++;
                if (rsp_valid !== 4'b0000) begin
                    bad++; $display("FAIL single_early_rsp cyc=%0d got=%b want=0000", c, rsp_valid);
                end
            end
            if (c == 6) begin
                total++;
                if (rsp_valid !== 4'b0001 || rsp_count[5:0] !== 6'd32 || busy !== 1'b1) begin
                    bad++; $display("FAIL single_rsp got v=%b cnt=%0d busy=%b want v=0001 cnt=32 busy=1",
                                    rsp_valid, rsp_count[5:0], busy);
                end
            end
            if (c == 7) begin
                total++;
                if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
                    bad++; $display("FAIL single_done got busy=%b v=%b want busy=0 v=0000", busy, rsp_valid);
                end
            end
            @(negedge clk);
        end
        $display("test_single done");
    endtask

    task automatic test_rotation();
        logic [3:0] rdy_tab [10];
        logic [3:0] rsp_tab [10];
        rdy_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4};
        rsp_tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
        apply_reset();
        req_data = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
        req_valid = '1; rsp_ready = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++;
            if (req_ready !== rdy_tab[c] || rsp_valid !== rsp_tab[c]) begin
                bad++; $display("FAIL rotation cyc=%0d got ready=%b rspv=%b want ready=%b rspv=%b",
                                c, req_ready, rsp_valid, rdy_tab[c], rsp_tab[c]);
            end
            if (c >= 6) begin
                total++;
                if (rsp_count[6*(c-6) +: 6] !== 6'(c - 5)) begin
                    bad++; $display("FAIL rotation_count cyc=%0d got=%0d want=%0d",
                                    c, rsp_count[6*(c-6) +: 6], c - 5);
                end
            end
            @(negedge clk);
        end
        $display("test_rotation done");
    endtask

    task automatic test_hold();
        logic [5:0] want2;
        apply_reset();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
        want2 = 6'($countones(req_data[95:64]));
        req_valid = '1;
        for (int c = 0; c < 36; c++) begin
            rsp_ready = (c < 26) ? 4'b1011 : 4'b1111;
            #1;
            total++;
            if (req_ready !== e_ready || rsp_valid !== e_rsp_valid || busy !== (|m_pend)) begin
                bad++; $display("FAIL hold_model cyc=%0d got ready=%b rspv=%b busy=%b want ready=%b rspv=%b busy=%b",
                                c, req_ready, rsp_valid, busy, e_ready, e_rsp_valid, |m_pend);
            end
            if (c >= 3 && c <= 26) begin
                total++;
                if (req_ready[2] !== 1'b0) begin
                    bad++; $display("FAIL hold_no_regrant cyc=%0d got=%b want=0", c, req_ready[2]);
                end
            end
            if (c >= 8 && c <= 26) begin
                total++;
                if (rsp_valid[2] !== 1'b1 || rsp_count[17:12] !== want2) begin
                    bad++; $display("FAIL hold_slot cyc=%0d got v=%b cnt=%0d want v=1 cnt=%0d",
                                    c, rsp_valid[2], rsp_count[17:12], want2);
                end
            end
            @(negedge clk);
        end
        $display("test_hold done");
    endtask

    task automatic test_ptr();
        apply_reset();
        rsp_ready = '0;
        req_data = {32'h1, 32'h3, 32'h7, 32'hF};
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: req_valid = 4'b0100;
                1: req_valid = 4'b1010;
                2: req_valid = 4'b0010;
                default: req_valid = 4'b0000;
            endcase
            #1;
            if (c == 1) begin
                total++;
                if (req_ready !== 4'b1000) begin
                    bad++; $display("FAIL ptr_grant3 got=%b want=1000", req_ready);
                end
            end
            if (c == 2) begin
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++; $display("FAIL ptr_grant1 got=%b want=0010", req_ready);
                end
            end
            if (c == 3) begin
                total++;
                if (dut.ptr_q !== 2'd2) begin
                    bad++; $display("FAIL ptr_value got=%0d want=2", dut.ptr_q);
                end
            end
            @(negedge clk);
        end
        $display("test_ptr done");
    endtask

    task automatic test_midflight_reset();
        apply_reset();
        req_data = {32'hFF, 32'hF0F0, 32'h3, 32'h1};
        req_valid = '1; rsp_ready = '1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, pc_valid, pc_in, rsp_valid, rsp_count, busy} !== '0) begin
            bad++; $display("FAIL flush_outputs got ready=%b pcv=%b pc_in=%h rspv=%b busy=%b want all 0",
                            req_ready, pc_valid, pc_in, rsp_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (c == 0) begin
                total++;
                if (req_ready !== 4'b0001) begin
                    bad++; $display("FAIL flush_first_grant got=%b want=0001", req_ready);
                end
            end
            total++;
            if (req_ready !== e_ready || rsp_valid !== e_rsp_valid || pc_in !== m_iss_w) begin
                bad++; $display("FAIL flush_model cyc=%0d got ready=%b rspv=%b pc_in=%h want ready=%b rspv=%b pc_in=%h",
                                c, req_ready, rsp_valid, pc_in, e_ready, e_rsp_valid, m_iss_w);
            end
            @(negedge clk);
        end
        $display("test_midflight_reset done");
    endtask

    task automatic test_lat0();
        apply_reset();
        rsp_ready0 = '1;
        for (int c = 0; c < 7; c++) begin
            req_valid0 = (c < 6) ? 4'b0010 : 4'b0000;
            req_data0[63:32] = (c == 0) ? 32'h0000_0000 : 32'h8000_0001;
            #1;
            case (c)
                0, 3: begin
                    total++;
                    if (req_ready0 !== 4'b0010) begin
                        bad++; $display("FAIL lat0_grant cyc=%0d got=%b want=0010", c, req_ready0);
                    end
                end
                1: begin
                    total++;
                    if (pc_valid0 !== 1'b1 || pc_in0 !== 32'h0 || req_ready0 !== 4'b0000) begin
                        bad++; $display("FAIL lat0_issue got v=%b d=%h ready=%b want v=1 d=0 ready=0000",
                                        pc_valid0, pc_in0, req_ready0);
                    end
                end
                2: begin
                    total++;
                    if (rsp_valid0 !== 4'b0010 || rsp_count0[11:6] !== 6'd0) begin
                        bad++; $display("FAIL lat0_rsp0 got v=%b cnt=%0d want v=0010 cnt=0",
                                        rsp_valid0, rsp_count0[11:6]);
                    end
                end
                5: begin
                    total++;
                    if (rsp_valid0 !== 4'b0010 || rsp_count0[11:6] !== 6'd2) begin
                        bad++; $display("FAIL lat0_rsp1 got v=%b cnt=%0d want v=0010 cnt=2",
                                        rsp_valid0, rsp_count0[11:6]);
                    end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        $display("test_lat0 done");
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom);
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
            #1;
            total++;
            if (req_ready !== e_ready || rsp_valid !== e_rsp_valid || busy !== (|m_pend) ||
                pc_valid !== m_iss_v || pc_in !== m_iss_w) begin
                bad++; $display("FAIL random_ctrl cyc=%0d got ready=%b rspv=%b busy=%b pcv=%b pc_in=%h want ready=%b rspv=%b busy=%b pcv=%b pc_in=%h",
                                c, req_ready, rsp_valid, busy, pc_valid, pc_in,
                                e_ready, e_rsp_valid, |m_pend, m_iss_v, m_iss_w);
            end
            for (int i = 0; i < N; i++) begin
                if (e_rsp_valid[i]) begin
                    total++;
                    if (rsp_count[6*i +: 6] !== 6'($countones(m_word[i]))) begin
                        bad++; $display("FAIL random_count cyc=%0d req=%0d got=%0d want=%0d",
                                        c, i, rsp_count[6*i +: 6], $countones(m_word[i]));
                    end
                end
            end
            @(negedge clk);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_hold();
        test_ptr();
        test_midflight_reset();
        test_lat0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
